// File: rtl/ms6205_pkg.sv
// Shared types for the MS6205 view engine: view encodings, FSM states, blank character.
package ms6205_pkg;

  typedef enum logic [2:0] {
    VIEW_RESTART = 3'd0,
    VIEW_IRAM    = 3'd1,
    VIEW_DRAM    = 3'd2,
    VIEW_CIN     = 3'd3,
    VIEW_COUT    = 3'd4
  } view_e;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_WAIT,
    ST_DATA,
    ST_DATA_WAIT
  } state_e;

  localparam logic [6:0] SPACE = 7'h20;

  // One-hot {COUT,CIN,DRAM,IRAM} request to view; lowest set bit wins.
  function automatic view_e view_from_req(input logic [3:0] req);
    view_e v;
    if (req[0])      v = VIEW_IRAM;
    else if (req[1]) v = VIEW_DRAM;
    else if (req[2]) v = VIEW_CIN;
    else             v = VIEW_COUT;
    return v;
  endfunction

endpackage

// File: rtl/ms6205_wr_port.sv
// Display write port: latches address/character on start, drives the registered
// strobes for the current phase and reports wait completion or timeout.
module ms6205_wr_port
  import ms6205_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic       Clock_1ms,
  input  logic       Rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [6:0] chr,
  input  state_e     phase,
  input  logic       disp_ready,
  output logic       done,
  output logic       timeout,
  output logic [7:0] disp_addr,
  output logic [7:0] disp_data,
  output logic       disp_write_addr,
  output logic       disp_write_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          waiting;
  logic          expired;

  assign waiting = (phase == ST_ADDR_WAIT) || (phase == ST_DATA_WAIT);
  assign expired = (wait_cnt == CW'(TIMEOUT - 1));
  // A wait ends on disp_ready, or on its last allowed cycle as if ready.
  assign done    = waiting && (disp_ready || expired);
  assign timeout = waiting && !disp_ready && expired;

  always_ff @(posedge Clock_1ms or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt <= '0;
    end else if (!waiting || done) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // The display bus carries the inverted character with bit 7 low.
  always_ff @(posedge Clock_1ms or negedge Rst_n) begin
    if (!Rst_n) begin
      disp_addr       <= 8'h00;
      disp_data       <= 8'h7F;
      disp_write_addr <= 1'b0;
      disp_write_data <= 1'b0;
    end else begin
      if (start) begin
        disp_addr <= addr;
        disp_data <= {1'b0, ~chr};
      end
      disp_write_addr <= (phase == ST_ADDR);
      disp_write_data <= (phase == ST_DATA);
    end
  end

endmodule

// File: rtl/ms6205_view_engine.sv
// MS6205 view engine: clears the screen, forwards character writes to the display
// and tracks the selected view. Build option: MS6205_CLEAR_ON_VIEW_EN.
// Handshake: cell_* is taken on a cycle where cell_valid && cell_ready are both high.
module ms6205_view_engine
  import ms6205_pkg::*;
#(
  parameter int COLUMNS = 16,
  parameter int ROWS    = 10,
  parameter int TIMEOUT = 8
) (
  input  logic       Clock_1ms,
  input  logic       Rst_n,
  input  logic [3:0] view_req,
  input  logic       hard_rst,
  input  logic       cell_valid,
  input  logic [7:0] cell_addr,
  input  logic [6:0] cell_char,
  output logic       cell_ready,
  input  logic       run_state,
  output logic [7:0] disp_addr,
  output logic [7:0] disp_data,
  output logic       disp_write_addr,
  output logic       disp_write_data,
  input  logic       disp_ready,
  output logic       marker,
  output logic [2:0] current_view,
  output logic       timeout_err
);

  localparam int         CELLS     = COLUMNS * ROWS;
  localparam logic [7:0] LAST_CELL = 8'(CELLS - 1);

  if (CELLS > 256 || CELLS < 1) begin : g_size_check
    $error("ms6205_view_engine: COLUMNS*ROWS must be in 1..256");
  end

  state_e     state, state_nx;
  logic [7:0] clr_idx, clr_idx_nx;
  logic       clr_mode, clr_mode_nx;
  logic       keep_view, keep_view_nx;
  view_e      cur_view, cur_view_nx;
  logic       pend_valid, pend_valid_nx;
  view_e      pend_view, pend_view_nx;
  logic       hard_pend, hard_pend_nx;

  logic       wr_start;
  logic [7:0] wr_addr;
  logic [6:0] wr_char;
  logic       wr_done;
  logic       wr_timeout;

  logic       view_apply;
  view_e      new_view;
  logic       idle_take;

  assign current_view = cur_view;

  always_ff @(posedge Clock_1ms or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_CLEAR;
      clr_idx    <= 8'h00;
      clr_mode   <= 1'b1;
      keep_view  <= 1'b0;
      cur_view   <= VIEW_RESTART;
      pend_valid <= 1'b0;
      pend_view  <= VIEW_RESTART;
      hard_pend  <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_idx    <= clr_idx_nx;
      clr_mode   <= clr_mode_nx;
      keep_view  <= keep_view_nx;
      cur_view   <= cur_view_nx;
      pend_valid <= pend_valid_nx;
      pend_view  <= pend_view_nx;
      hard_pend  <= hard_pend_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    clr_idx_nx    = clr_idx;
    clr_mode_nx   = clr_mode;
    keep_view_nx  = keep_view;
    cur_view_nx   = cur_view;
    pend_valid_nx = pend_valid;
    pend_view_nx  = pend_view;
    hard_pend_nx  = hard_pend;
    wr_start      = 1'b0;
    wr_addr       = clr_idx;
    wr_char       = SPACE;
    cell_ready    = 1'b0;
    view_apply    = 1'b0;
    new_view      = pend_view;
    idle_take     = 1'b1;

    // Newest request wins, otherwise whatever was parked while busy.
    if (|view_req) begin
      view_apply = 1'b1;
      new_view   = view_from_req(view_req);
    end else if (pend_valid) begin
      view_apply = 1'b1;
    end

    if (state != ST_IDLE) begin
      if (|view_req) begin
        pend_valid_nx = 1'b1;
        pend_view_nx  = view_from_req(view_req);
      end
      if (hard_rst && !clr_mode) hard_pend_nx = 1'b1;
    end

    case (state)
      ST_CLEAR: begin
        wr_start = 1'b1;
        state_nx = ST_ADDR;
      end
      ST_IDLE: begin
        if (hard_rst || hard_pend) begin
          state_nx      = ST_CLEAR;
          clr_idx_nx    = 8'h00;
          clr_mode_nx   = 1'b1;
          keep_view_nx  = 1'b0;
          cur_view_nx   = VIEW_RESTART;
          hard_pend_nx  = 1'b0;
          pend_valid_nx = 1'b0;
        end else begin
          if (view_apply) begin
            cur_view_nx   = new_view;
            pend_valid_nx = 1'b0;
          end
`ifdef MS6205_CLEAR_ON_VIEW_EN
          if (view_apply) begin
            idle_take    = 1'b0;
            state_nx     = ST_CLEAR;
            clr_idx_nx   = 8'h00;
            clr_mode_nx  = 1'b1;
            keep_view_nx = 1'b1;
          end
`endif
          if (idle_take) begin
            cell_ready = 1'b1;
            // Out-of-range cells are taken but never reach the display.
            if (cell_valid && ({1'b0, cell_addr} < 9'(CELLS))) begin
              wr_start = 1'b1;
              wr_addr  = cell_addr;
              wr_char  = cell_char;
              state_nx = ST_ADDR;
            end
          end
        end
      end
      ST_ADDR:      state_nx = ST_ADDR_WAIT;
      ST_ADDR_WAIT: if (wr_done) state_nx = ST_DATA;
      ST_DATA:      state_nx = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        if (wr_done) begin
          if (!clr_mode) begin
            state_nx = ST_IDLE;
          end else if (clr_idx == LAST_CELL) begin
            state_nx    = ST_IDLE;
            clr_mode_nx = 1'b0;
            if (!keep_view) cur_view_nx = VIEW_IRAM;
          end else begin
            clr_idx_nx = clr_idx + 8'd1;
            state_nx   = ST_CLEAR;
          end
        end
      end
      default: state_nx = ST_CLEAR;
    endcase

    // A restart request while clearing abandons the current cell and starts over.
    if (clr_mode && hard_rst) begin
      wr_start      = 1'b0;
      state_nx      = ST_CLEAR;
      clr_idx_nx    = 8'h00;
      keep_view_nx  = 1'b0;
      cur_view_nx   = VIEW_RESTART;
      pend_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge Clock_1ms or negedge Rst_n) begin
    if (!Rst_n) begin
      marker      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      marker      <= (cur_view == VIEW_IRAM) && run_state;
      timeout_err <= timeout_err | wr_timeout;
    end
  end

  ms6205_wr_port #(
    .TIMEOUT(TIMEOUT)
  ) u_wr_port (
    .Clock_1ms      (Clock_1ms),
    .Rst_n          (Rst_n),
    .start          (wr_start),
    .addr           (wr_addr),
    .chr            (wr_char),
    .phase          (state),
    .disp_ready     (disp_ready),
    .done           (wr_done),
    .timeout        (wr_timeout),
    .disp_addr      (disp_addr),
    .disp_data      (disp_data),
    .disp_write_addr(disp_write_addr),
    .disp_write_data(disp_write_data)
  );

endmodule

// File: doc/ms6205_view_engine.md
MS6205_VIEW_ENGINE -- requirements
Module: ms6205_view_engine

Interface
REQ-001 SHALL have parameter COLUMNS, default 16, characters per row.
REQ-002 SHALL have parameter ROWS, default 10, rows per screen; COLUMNS*ROWS SHALL be <= 256, checked by elaboration assertion.
REQ-003 SHALL have parameter TIMEOUT, default 8, Clock_1ms cycles to wait for disp_ready before abandoning a write.
REQ-004 SHALL have ports, in this order:
- Clock_1ms  in  1  system clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- view_req  in  4  one-hot view request {COUT,CIN,DRAM,IRAM}; bit0 = IRAM.
- hard_rst  in  1  request screen clear and restart.
- cell_valid  in  1  character write request.
- cell_addr  in  8  linear cell index, row*COLUMNS+col.
- cell_char  in  7  ASCII character.
- cell_ready  out  1  engine accepts cell_* this cycle.
- run_state  in  1  CPU running; enables marker.
- disp_addr  out  8  display address bus.
- disp_data  out  8  display data bus, {1'b0, ~char[6:0]}.
- disp_write_addr  out  1  one-cycle address strobe.
- disp_write_data  out  1  one-cycle data strobe.
- disp_ready  in  1  display idle.
- marker  out  1  cursor marker enable.
- current_view  out  3  0 RESTART, 1 IRAM, 2 DRAM, 3 CIN, 4 COUT.
- timeout_err  out  1  sticky, a write timed out.

Function
REQ-005 SHALL run FSM states CLEAR, IDLE, ADDR, ADDR_WAIT, DATA, DATA_WAIT.
REQ-006 CLEAR SHALL write space (0x20) to every cell 0..COLUMNS*ROWS-1 in ascending order, each via the full ADDR/DATA handshake, then enter IDLE with current_view = IRAM.
REQ-007 IDLE SHALL assert cell_ready; when cell_valid && cell_ready, it SHALL latch cell_addr/cell_char and go to ADDR.
REQ-008 cell_addr >= COLUMNS*ROWS SHALL be accepted and dropped (no display write), with return to IDLE next cycle.
REQ-009 ADDR SHALL drive disp_addr and pulse disp_write_addr for exactly one cycle, then go to ADDR_WAIT.
REQ-010 ADDR_WAIT SHALL advance to DATA on the first cycle disp_ready = 1.
REQ-011 DATA SHALL pulse disp_write_data for one cycle with disp_data valid; DATA_WAIT SHALL return to IDLE (or the next CLEAR cell) on disp_ready = 1.
REQ-012 If either wait state lasts TIMEOUT cycles without disp_ready, the FSM SHALL proceed as if ready and set timeout_err.
REQ-013 In IDLE, a nonzero view_req SHALL update current_view next cycle; the lowest set bit wins if more than one is set.
REQ-014 A view change outside IDLE SHALL be held pending and applied on the next IDLE cycle; a later request overwrites a pending one.
REQ-015 hard_rst SHALL take priority over cell_valid and view_req: enter CLEAR at the next IDLE cycle, current_view = RESTART, cell_ready low until CLEAR completes.
REQ-016 hard_rst during CLEAR SHALL restart CLEAR from cell 0.
REQ-017 marker SHALL equal (current_view == IRAM) && run_state, registered.
REQ-018 Write latency from accepted cell_valid to disp_write_data SHALL be 3 cycles when disp_ready is held high.

Reset
REQ-019 Rst_n low SHALL set state CLEAR at cell 0, current_view = RESTART, disp_addr = 0, disp_data = 0x7F (inverted 0x00), strobes = 0, cell_ready = 0, marker = 0, timeout_err = 0, no pending view.
REQ-020 Reset mid-write SHALL abandon the write without completing the handshake.

Configuration
REQ-021 With MS6205_CLEAR_ON_VIEW_EN defined, every applied view change SHALL first run CLEAR while holding the new current_view; without it, view changes SHALL leave screen contents untouched.

Structure
REQ-022 View encodings, the FSM state enum and the SPACE constant SHALL live in package ms6205_pkg.
REQ-023 The handshake/timeout logic SHALL be sub-module ms6205_wr_port, which takes addr/char/start and returns done/timeout.

Verification
REQ-024 Reset released, disp_ready = 1 -> 160 address/data strobe pairs of 0x00..0x9F, data 0x5F, then current_view = 1.
REQ-025 IDLE, cell_addr = 5, cell_char = 'A' -> disp_addr = 5, disp_data = 0x3E, disp_write_data 3 cycles after acceptance.
REQ-026 disp_ready held 0 -> timeout_err = 1 after 8 cycles, FSM returns to IDLE.
REQ-027 view_req = 4'b0110 during a write -> current_view = 2 on the first IDLE cycle after the write.
REQ-028 hard_rst at cell 80 of CLEAR -> next address strobe is 0x00.
REQ-029 current_view = 1, run_state = 1 -> marker = 1; switch to COUT -> marker = 0.
